// File: rtl/xlnx_boot_seq_pkg.sv
// Shared types and default parameter values for the board boot sequencer.
package xlnx_boot_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_DRAM_RST   = 3'd1,
        ST_WAIT_CALIB = 3'd2,
        ST_SOC_RST    = 3'd3,
        ST_RUN        = 3'd4,
        ST_ERROR      = 3'd5
    } state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 1000;
    localparam int DRAM_RST_CYCLES_DEF = 64;
    localparam int SOC_RST_CYCLES_DEF  = 16;
    localparam int CALIB_TIMEOUT_DEF   = 2**24 - 1;
    localparam int USE_DRAM_DEF        = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/xlnx_rst_debounce.sv
// Synchronizes the button and debug reset requests, ORs them, and debounces the result.
module xlnx_rst_debounce
    import xlnx_boot_seq_pkg::*;
#(
    parameter int Cycles = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cpu_rst_i,
    input  logic vio_rst_i,
    output logic req_o
);

    localparam int CntW = $clog2(Cycles) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

    logic [1:0]      r_cpu_sync;
    logic [1:0]      r_vio_sync;
    logic [CntW-1:0] r_cnt;
    logic            w_raw;

    assign w_raw = r_cpu_sync[1] | r_vio_sync[1];

    // r_cnt holds how many earlier consecutive cycles the raw request was high
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cpu_sync <= '0;
            r_vio_sync <= '0;
            r_cnt      <= '0;
        end else begin
            r_cpu_sync <= {r_cpu_sync[0], cpu_rst_i};
            r_vio_sync <= {r_vio_sync[0], vio_rst_i};
            if (!w_raw) begin
                r_cnt <= '0;
            end else if (r_cnt != CntLast) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign req_o = w_raw && (r_cnt == CntLast);

endmodule

// File: rtl/xlnx_boot_seq.sv
// Board boot sequencer: waits for clock lock, pulses DRAM reset, waits for calibration,
// then releases the SoC reset and latches the boot mode.
// state      | meaning
// WAIT_LOCK  | all resets held until the clock wizard locks
// DRAM_RST   | DRAM controller reset pulse
// WAIT_CALIB | waiting for DRAM calibration, bounded by a timeout
// SOC_RST    | SoC reset pulse before release
// RUN        | SoC running, boot mode latched
// ERROR      | fault hold; only a debounced reset request leaves
module xlnx_boot_seq
    import xlnx_boot_seq_pkg::*;
#(
    parameter int DebounceCycles = DEBOUNCE_CYCLES_DEF,
    parameter int DramRstCycles  = DRAM_RST_CYCLES_DEF,
    parameter int SocRstCycles   = SOC_RST_CYCLES_DEF,
    parameter int CalibTimeout   = CALIB_TIMEOUT_DEF,
    parameter int UseDram        = USE_DRAM_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clk_locked_i,
    input  logic       calib_done_i,
    input  logic       cpu_rst_i,
    input  logic       vio_rst_i,
    input  logic [1:0] boot_mode_sw_i,
    input  logic [1:0] vio_boot_mode_i,
    input  logic       vio_boot_mode_sel_i,
    output logic       dram_rst_o,
    output logic       soc_rst_no,
    output logic [1:0] boot_mode_o,
    output logic       err_o,
    output logic [2:0] state_o
);

    localparam int CntW = $clog2(max3(DramRstCycles, SocRstCycles, CalibTimeout)) + 1;
    localparam logic [CntW-1:0] DramLast  = CntW'(DramRstCycles - 1);
    localparam logic [CntW-1:0] SocLast   = CntW'(SocRstCycles - 1);
    localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeout - 1);

    logic [1:0]      r_lock_sync;
    logic [1:0]      r_calib_sync;
    logic [CntW-1:0] r_cnt;
    logic [1:0]      r_boot_mode;
    state_e          r_state;
    state_e          w_state_next;
    logic            w_lock;
    logic            w_calib;
    logic            w_req;
    logic            w_use_dram;

    assign w_use_dram = (UseDram != 0);
    assign w_lock     = r_lock_sync[1];
    assign w_calib    = r_calib_sync[1];

    xlnx_rst_debounce #(
        .Cycles(DebounceCycles)
    ) u_rst_debounce (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .cpu_rst_i(cpu_rst_i),
        .vio_rst_i(vio_rst_i),
        .req_o    (w_req)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lock_sync  <= '0;
            r_calib_sync <= '0;
            r_state      <= ST_WAIT_LOCK;
            r_cnt        <= '0;
            r_boot_mode  <= '0;
        end else begin
            r_lock_sync  <= {r_lock_sync[0], clk_locked_i};
            r_calib_sync <= {r_calib_sync[0], calib_done_i};
            r_state      <= w_state_next;
            // saturate rather than wrap so a long dwell can never fake a terminal count
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_SOC_RST && w_state_next == ST_RUN) begin
                r_boot_mode <= vio_boot_mode_sel_i ? vio_boot_mode_i : boot_mode_sw_i;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        dram_rst_o   = 1'b0;
        soc_rst_no   = 1'b0;
        err_o        = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                dram_rst_o = 1'b1;
                if (w_lock) w_state_next = w_use_dram ? ST_DRAM_RST : ST_SOC_RST;
            end
            ST_DRAM_RST: begin
                dram_rst_o = 1'b1;
                if (r_cnt == DramLast) w_state_next = ST_WAIT_CALIB;
            end
            ST_WAIT_CALIB: begin
                if (w_calib) w_state_next = ST_SOC_RST;
                else if (r_cnt == CalibLast) w_state_next = ST_ERROR;
            end
            ST_SOC_RST: begin
                if (r_cnt == SocLast) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                soc_rst_no = 1'b1;
                if (!w_lock) w_state_next = ST_WAIT_LOCK;
                else if (w_use_dram && !w_calib) w_state_next = ST_ERROR;
            end
            ST_ERROR: begin
                dram_rst_o = 1'b1;
                err_o      = 1'b1;
            end
            default: begin
                dram_rst_o   = 1'b1;
                w_state_next = ST_WAIT_LOCK;
            end
        endcase
        // without DRAM the controller stays parked in reset for the whole run
        if (!w_use_dram) dram_rst_o = 1'b1;
        if (w_req) w_state_next = ST_WAIT_LOCK;
    end

    assign boot_mode_o = r_boot_mode;
    assign state_o     = r_state;

endmodule

// File: tb/tb_xlnx_boot_seq.sv
// Scoreboard bench: three sequencer configurations share stimulus; each output change is checked.
module tb_xlnx_boot_seq;

    typedef struct {
        int         inst;
        logic [7:0] obs;
        int         dwell;
    } exp_t;

    logic       clk;
    logic [2:0] rst_n;
    logic       lock, calib, cpu_rst, vio_rst, sel;
    logic [1:0] sw, vio_bm;
    logic [2:0] dram, socn, err;
    logic [1:0] bm [3];
    logic [2:0] st [3];
    logic [7:0] obs [3];
    logic [7:0] prev [3];
    int         dw [3];
    exp_t       sb [$];
    exp_t       ev;
    int         checks = 0;
    int         passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    xlnx_boot_seq u_dut_nom (
        .clk_i(clk), .rst_ni(rst_n[0]), .clk_locked_i(lock), .calib_done_i(calib),
        .cpu_rst_i(cpu_rst), .vio_rst_i(vio_rst), .boot_mode_sw_i(sw),
        .vio_boot_mode_i(vio_bm), .vio_boot_mode_sel_i(sel), .dram_rst_o(dram[0]),
        .soc_rst_no(socn[0]), .boot_mode_o(bm[0]), .err_o(err[0]), .state_o(st[0])
    );

    xlnx_boot_seq #(.CalibTimeout(100)) u_dut_to (
        .clk_i(clk), .rst_ni(rst_n[1]), .clk_locked_i(lock), .calib_done_i(calib),
        .cpu_rst_i(cpu_rst), .vio_rst_i(vio_rst), .boot_mode_sw_i(sw),
        .vio_boot_mode_i(vio_bm), .vio_boot_mode_sel_i(sel), .dram_rst_o(dram[1]),
        .soc_rst_no(socn[1]), .boot_mode_o(bm[1]), .err_o(err[1]), .state_o(st[1])
    );

    xlnx_boot_seq #(.UseDram(0)) u_dut_nodram (
        .clk_i(clk), .rst_ni(rst_n[2]), .clk_locked_i(lock), .calib_done_i(calib),
        .cpu_rst_i(cpu_rst), .vio_rst_i(vio_rst), .boot_mode_sw_i(sw),
        .vio_boot_mode_i(vio_bm), .vio_boot_mode_sel_i(sel), .dram_rst_o(dram[2]),
        .soc_rst_no(socn[2]), .boot_mode_o(bm[2]), .err_o(err[2]), .state_o(st[2])
    );

    assign obs[0] = {st[0], dram[0], socn[0], err[0], bm[0]};
    assign obs[1] = {st[1], dram[1], socn[1], err[1], bm[1]};
    assign obs[2] = {st[2], dram[2], socn[2], err[2], bm[2]};

    // dwell = cycles spent in the state being left; -1 means not checked
    function automatic void push_exp(input int inst, input logic [2:0] s, input logic d,
                                     input logic sn, input logic e, input logic [1:0] b,
                                     input int dwell);
        exp_t x;
        x.inst  = inst;
        x.obs   = {s, d, sn, e, b};
        x.dwell = dwell;
        sb.push_back(x);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            dw[k] = dw[k] + 1;
            if (obs[k] !== prev[k]) begin
                prev[k] = obs[k];
                checks++;
                if (sb.size() == 0 || sb[0].inst != k) begin
                    $display("FAIL unexpected_change inst%0d actual=%h required=no change", k, obs[k]);
                end else begin
                    ev = sb.pop_front();
                    if (obs[k] === ev.obs) passed++;
                    else $display("FAIL outputs inst%0d actual=%h required=%h", k, obs[k], ev.obs);
                    if (ev.dwell >= 0) begin
                        checks++;
                        if (dw[k] == ev.dwell) passed++;
                        else $display("FAIL dwell inst%0d state=%0d actual=%0d required=%0d",
                                      k, obs[k][7:5], dw[k], ev.dwell);
                    end
                end
                dw[k] = 0;
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            prev[k] = 8'hFF;
            dw[k]   = 0;
        end
        rst_n = 3'b000; lock = 0; calib = 0; cpu_rst = 0; vio_rst = 0;
        sel = 1; vio_bm = 2'b10; sw = 2'b01;
        for (int k = 0; k < 3; k++) push_exp(k, 3'd0, 1, 0, 0, 2'b00, -1);
        tick(3);

        // nominal sequence, vio boot mode selected
        rst_n[0] = 1;
        tick(10);
        push_exp(0, 3'd1, 1, 0, 0, 2'b00, -1);
        push_exp(0, 3'd2, 0, 0, 0, 2'b00, 64);
        lock = 1;
        tick(200);
        push_exp(0, 3'd3, 0, 0, 0, 2'b00, -1);
        push_exp(0, 3'd4, 0, 1, 0, 2'b10, 16);
        calib = 1;
        tick(40);
        sw = 2'b11; vio_bm = 2'b01; sel = 0;
        tick(10);

        // 999-cycle press is ignored; 1100-cycle press resequences
        cpu_rst = 1;
        tick(999);
        cpu_rst = 0;
        tick(20);
        push_exp(0, 3'd0, 1, 0, 0, 2'b10, -1);
        cpu_rst = 1;
        tick(1100);
        push_exp(0, 3'd1, 1, 0, 0, 2'b10, -1);
        push_exp(0, 3'd2, 0, 0, 0, 2'b10, 64);
        push_exp(0, 3'd3, 0, 0, 0, 2'b10, 1);
        push_exp(0, 3'd4, 0, 1, 0, 2'b11, 16);
        cpu_rst = 0;
        tick(120);

        // lock loss must reach WAIT_LOCK within 3 cycles
        push_exp(0, 3'd0, 1, 0, 0, 2'b11, -1);
        lock = 0;
        tick(3);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL lock_drop_latency actual=%0d pending required=0 pending", sb.size());
        push_exp(0, 3'd1, 1, 0, 0, 2'b11, -1);
        push_exp(0, 3'd2, 0, 0, 0, 2'b11, 64);
        push_exp(0, 3'd3, 0, 0, 0, 2'b11, 1);
        push_exp(0, 3'd4, 0, 1, 0, 2'b11, 16);
        lock = 1;
        tick(100);
        push_exp(0, 3'd5, 1, 0, 1, 2'b11, -1);
        calib = 0;
        tick(10);
        push_exp(0, 3'd0, 1, 0, 0, 2'b00, -1);
        rst_n[0] = 0;
        tick(5);

        // calibration timeout, then debug reset recovery
        lock = 0;
        rst_n[1] = 1;
        tick(5);
        push_exp(1, 3'd1, 1, 0, 0, 2'b00, -1);
        push_exp(1, 3'd2, 0, 0, 0, 2'b00, 64);
        push_exp(1, 3'd5, 1, 0, 1, 2'b00, 100);
        lock = 1;
        tick(200);
        push_exp(1, 3'd0, 1, 0, 0, 2'b00, -1);
        vio_rst = 1;
        tick(1010);
        push_exp(1, 3'd1, 1, 0, 0, 2'b00, -1);
        push_exp(1, 3'd2, 0, 0, 0, 2'b00, 64);
        push_exp(1, 3'd3, 0, 0, 0, 2'b00, 1);
        push_exp(1, 3'd4, 0, 1, 0, 2'b11, 16);
        vio_rst = 0; calib = 1;
        tick(120);
        push_exp(1, 3'd0, 1, 0, 0, 2'b00, -1);
        rst_n[1] = 0;
        tick(3);

        // no DRAM: straight to SOC_RST, DRAM reset held, calib ignored
        lock = 0; calib = 0;
        rst_n[2] = 1;
        tick(5);
        sel = 1; vio_bm = 2'b01;
        push_exp(2, 3'd3, 1, 0, 0, 2'b00, -1);
        push_exp(2, 3'd4, 1, 1, 0, 2'b01, 16);
        lock = 1;
        tick(40);
        calib = 1;
        tick(5);
        calib = 0;
        tick(10);
        push_exp(2, 3'd0, 1, 0, 0, 2'b01, -1);
        lock = 0;
        tick(10);

        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain actual=%0d pending required=0 pending", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/xlnx_boot_seq.md
XLNX_BOOT_SEQ -- requirements
Module: xlnx_boot_seq

Interface
REQ-001 Parameter DebounceCycles, default 1000: consecutive cycles a reset request must persist before it is accepted.
REQ-002 Parameter DramRstCycles, default 64: cycles dram_rst_o is held high in DRAM_RST.
REQ-003 Parameter SocRstCycles, default 16: cycles soc_rst_no is held low in SOC_RST.
REQ-004 Parameter CalibTimeout, default 2**24-1: maximum wait in WAIT_CALIB, in cycles.
REQ-005 Parameter UseDram, default 1: 0 means DRAM_RST and WAIT_CALIB are skipped.
REQ-006 clk_i  in  1  SoC clock; single clock domain for all logic.
REQ-007 rst_ni  in  1  reset, synchronous, active-low.
REQ-008 clk_locked_i  in  1  clock wizard lock; asynchronous.
REQ-009 calib_done_i  in  1  DRAM controller calibration complete; asynchronous.
REQ-010 cpu_rst_i  in  1  board reset button, active-high; asynchronous.
REQ-011 vio_rst_i  in  1  debug reset request, active-high; asynchronous.
REQ-012 boot_mode_sw_i  in  2  board switch boot mode.
REQ-013 vio_boot_mode_i  in  2  debug boot mode.
REQ-014 vio_boot_mode_sel_i  in  1  1 selects vio_boot_mode_i.
REQ-015 dram_rst_o  out  1  DRAM controller reset, active-high.
REQ-016 soc_rst_no  out  1  SoC reset, active-low.
REQ-017 boot_mode_o  out  2  latched boot mode.
REQ-018 err_o  out  1  high in ERROR.
REQ-019 state_o  out  3  current state encoding.

Function
REQ-020 clk_locked_i, calib_done_i, cpu_rst_i and vio_rst_i SHALL each pass through a 2-flop synchronizer before any use.
REQ-021 The reset request is the OR of synced cpu_rst and vio_rst; the debounced request SHALL rise after the raw request has been high for DebounceCycles consecutive cycles, and SHALL fall in the first cycle the raw request is low.
REQ-022 States: WAIT_LOCK=0, DRAM_RST=1, WAIT_CALIB=2, SOC_RST=3, RUN=4, ERROR=5.
REQ-023 WAIT_LOCK: on synced lock, go to DRAM_RST, or to SOC_RST if UseDram=0.
REQ-024 DRAM_RST: dram_rst_o=1 for exactly DramRstCycles cycles, then go to WAIT_CALIB.
REQ-025 WAIT_CALIB: dram_rst_o=0; on synced calib_done, go to SOC_RST; if CalibTimeout cycles elapse first, go to ERROR.
REQ-026 SOC_RST: soc_rst_no=0 for exactly SocRstCycles cycles, then go to RUN.
REQ-027 On the SOC_RST->RUN transition, boot_mode_o SHALL load (vio_boot_mode_sel_i ? vio_boot_mode_i : boot_mode_sw_i); boot_mode_o is held constant in every other cycle.
REQ-028 RUN: soc_rst_no=1; loss of synced lock goes to WAIT_LOCK; loss of synced calib_done (UseDram=1) goes to ERROR.
REQ-029 ERROR: dram_rst_o=1, soc_rst_no=0, err_o=1; leave only through a debounced request.
REQ-030 The debounced request SHALL force WAIT_LOCK from any state while high, with priority over all other transitions.
REQ-031 soc_rst_no=0 in every state except RUN.
REQ-032 dram_rst_o=1 in WAIT_LOCK, DRAM_RST and ERROR.
REQ-033 The single shared cycle counter SHALL clear on every state change; counter width is $clog2 of the largest count parameter plus 1; no wrap is permitted.

Reset
REQ-034 While rst_ni=0 at a clk_i edge: state=WAIT_LOCK, dram_rst_o=1, soc_rst_no=0, boot_mode_o=0, err_o=0, counters and synchronizers cleared.
REQ-035 Assertion of rst_ni mid-sequence SHALL abort the sequence with no other side effects.

Structure
REQ-036 The state enum and default parameter values SHALL reside in a shared package, xlnx_boot_seq_pkg.
REQ-037 Synchronizer plus debouncer SHALL be one sub-module, xlnx_rst_debounce, instantiated once for the OR'ed request; lock and calib use plain synchronizers.

Verification
REQ-038 Nominal: lock at cycle 10, calib 200 cycles later -> dram_rst_o high for 64 cycles, soc_rst_no rises 16 cycles after calib (plus sync latency), state_o=4.
REQ-039 Boot mode: sel=1, vio=2'b10, sw=2'b01 at SOC_RST exit -> boot_mode_o=2'b10; changing sw/vio in RUN -> no change.
REQ-040 Button glitch: cpu_rst_i high for 999 cycles -> no effect; high for 1000 cycles -> soc_rst_no=0 and state_o=0 until release, then full resequence.
REQ-041 Timeout: CalibTimeout=100, calib never asserted -> ERROR after 100 cycles, err_o=1; vio_rst_i debounced -> recovers.
REQ-042 Lock drop in RUN -> state_o=0 and soc_rst_no=0 within 3 cycles; calib drop in RUN -> ERROR.
REQ-043 UseDram=0: lock -> SOC_RST directly, dram_rst_o stays 1, and soc_rst_no rises after 16 cycles.
